uart8_receiver: RTL and testbench
=================================

UART8_RECEIVER -- requirements
Module: Uart8Receiver

Interface
REQ-001 SHALL have parameter: SAMPLES_PER_BIT, default 16, clk cycles per bit period; legal values are even and >= 4.
REQ-002 SHALL have port: clk  input  1  oversampling clock, SAMPLES_PER_BIT x baud rate; sole clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: en  input  1  enable; low forces RESET state.
REQ-005 SHALL have port: in  input  1  rx line, asynchronous, idles high.
REQ-006 SHALL have port: out  output  8  last received data byte.
REQ-007 SHALL have port: busy  output  1  frame reception in progress.
REQ-008 SHALL have port: done  output  1  one-clk pulse, frame complete, out valid.
REQ-009 SHALL have port: err  output  1  framing error, stop bit sampled low.

Function
REQ-010 SHALL pass in through a 2-flop synchronizer (rx_s) before any use; no logic reads raw in.
REQ-011 SHALL implement states RESET, IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_IDLE; unused encodings go to RESET.
REQ-012 SHALL, in RESET: clear busy, done, err, sample counter, bit index; go to IDLE when en=1.
REQ-013 SHALL, in IDLE: on rx_s=0 go to START_BIT with sample counter cleared.
REQ-014 SHALL assert busy on entry to START_BIT and hold it through the STOP_BIT sample.
REQ-015 SHALL, in START_BIT: count to SAMPLES_PER_BIT/2-1 (mid-bit), then sample rx_s: 1 -> false start, return to IDLE, busy low; 0 -> go to DATA_BITS, counter cleared.
REQ-016 SHALL, in DATA_BITS: sample rx_s every SAMPLES_PER_BIT clks (bit centre); shift bits in LSB first; bit index 0..7.
REQ-017 SHALL go to STOP_BIT after the bit-7 sample; no parity bit.
REQ-018 SHALL, in STOP_BIT: sample rx_s after SAMPLES_PER_BIT clks.
REQ-019 SHALL, on a stop sample of 1: load out with the shifted byte, pulse done for exactly one clk, clear err, drop busy, go to IDLE.
REQ-020 SHALL, on a stop sample of 0: load out with the shifted byte, pulse done for one clk, set err, drop busy, go to WAIT_IDLE.
REQ-021 SHALL, in WAIT_IDLE: stay until rx_s=1, then go to IDLE; a held-low line (break) produces no further frames.
REQ-022 SHALL hold err until the next done pulse; a successful frame clears it.
REQ-023 SHALL hold out stable between done pulses; out is never updated without done.
REQ-024 SHALL assert done no later than 9*SAMPLES_PER_BIT + SAMPLES_PER_BIT/2 + 4 clks after the falling edge of in.
REQ-025 SHALL accept a start edge detected in IDLE the clk immediately after a stop-bit done; back-to-back frames are received without loss.
REQ-026 SHALL wrap the sample counter to 0 at SAMPLES_PER_BIT-1; bit index is 3 bits and wraps only on the STOP_BIT transition.
REQ-027 SHALL, when en=0, go to RESET on the next clk from any state; an in-flight frame is discarded and done is not pulsed.

Reset
REQ-028 SHALL, with rst=1 at a clk edge, set out=8'h00, busy=0, done=0, err=0, synchronizer flops=1, state=RESET.
REQ-029 SHALL give rst priority over en and all state activity; reset mid-frame discards the frame with no done pulse.
REQ-030 SHALL resume in IDLE no earlier than 1 clk after rst falls (with en=1); a line already low at that point is treated as a start edge.

Verification
REQ-031 SHALL be verified: S=16, send 0x55 frame, stop=1 -> out=8'h55, one-clk done, err=0, busy low after.
REQ-032 SHALL be verified: in low for 4 clks then high -> busy pulses, START_BIT aborts, no done, out unchanged.
REQ-033 SHALL be verified: send 0xA3 with stop bit 0, line held low 40 clks -> out=8'hA3, done once, err=1, no second frame until line high.
REQ-034 SHALL be verified: back-to-back 0xA3 then 0x3C, one stop bit each -> two done pulses, out=8'hA3 then 8'h3C, err=0.
REQ-035 SHALL be verified: rst asserted during data bit 4 of 0xFF -> outputs at reset values, no done; next frame 0x81 received correctly.
REQ-036 SHALL be verified: en dropped during DATA_BITS for 3 clks -> frame discarded, no done; next frame 0x0F received correctly.

Source files
------------

// File: rtl/uart8_receiver.sv
// uart8_receiver: 8N1 UART receiver running on an oversampling clock.
// The rx line is synchronized and the start edge is detected in IDLE.
// Each bit is then sampled at its centre, LSB first. The received byte is
// published on out together with a one-clock done pulse. A low stop bit
// flags a framing error, and the receiver then waits for the line to go high.
module uart8_receiver #(
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int                CNT_W     = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        IDLE      = 3'd1,
        START_BIT = 3'd2,
        DATA_BITS = 3'd3,
        STOP_BIT  = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rx_meta, rx_s;

    // Two-flop synchronizer for the asynchronous rx line; idles high out of reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= in;
            rx_s    <= rx_meta;
        end
    end

    // Control and output register bank; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Data shift register; contents only reach out through a completed frame.
    // NOTE: no reset here on purpose -- a stale byte is always fully overwritten before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Next-state and datapath logic for the receive FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (!en) begin
            // Dropping enable discards any frame in flight without a done pulse.
            state_d = RESET;
            cnt_d   = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START_BIT;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                START_BIT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            // Line went back high before mid-bit: glitch, not a start.
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = DATA_BITS;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DATA_BITS: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = STOP_BIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STOP_BIT: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d   = '0;
                        out_d   = shift_q;
                        done_d  = 1'b1;
                        err_d   = !rx_s;
                        busy_d  = 1'b0;
                        state_d = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low (break) line must return high before a new frame.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = RESET;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// tb_uart8_receiver: directed self-checking bench for uart8_receiver at 16x oversampling.
module tb_uart8_receiver;

    localparam int SPB     = 16;
    localparam int LAT_MAX = 9 * SPB + SPB / 2 + 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state, written only by the monitor / cycle counter.
    int         cyc        = 0;
    int         done_count = 0;
    int         done_cyc   = 0;
    int         busy_count = 0;
    int         done_long  = 0;
    int         out_glitch = 0;
    logic [7:0] out_prev;
    logic       done_prev  = 1'b0;
    logic [7:0] cap_out[$];
    logic       cap_err[$];

    int frame_start_cyc;

    uart8_receiver #(.SAMPLES_PER_BIT(SPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (rx),
        .out  (out),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the falling edge: records done pulses, busy activity and illegal out changes.
    always @(negedge clk) begin
        if (done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
            cap_out.push_back(out);
            cap_err.push_back(err);
            if (done_prev) done_long = done_long + 1;
        end
        if (busy) busy_count = busy_count + 1;
        if (!rst && !done && (out !== out_prev)) out_glitch = out_glitch + 1;
        out_prev  = out;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(SPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_val);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_val);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d0, b0, lat;
        logic [7:0] abort_byte;
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        wait_clks(3);

        // Reset state.
        check("rst_out",  32'(out),  32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err",  32'(err),  32'h0);
        rst = 1'b0;
        wait_clks(4);

        // 0x55 with a good stop bit.
        d0 = done_count;
        b0 = busy_count;
        send_frame(8'h55, 1'b1);
        lat = done_cyc - frame_start_cyc;
        check("t1_done_cnt", 32'(done_count - d0), 32'd1);
        check("t1_out",      32'(out),             32'h55);
        check("t1_err",      32'(err),             32'h0);
        check("t1_busy_end", 32'(busy),            32'h0);
        check("t1_busy_seen", 32'(busy_count > b0), 32'h1);
        check("t1_latency_ok", 32'(lat <= LAT_MAX && lat > 0), 32'h1);
        wait_clks(10);

        // Glitch: low for 4 clocks, then high -> false start.
        d0 = done_count;
        b0 = busy_count;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(30);
        check("t2_busy_pulse", 32'(busy_count > b0), 32'h1);
        check("t2_no_done",    32'(done_count - d0), 32'd0);
        check("t2_out_kept",   32'(out),             32'h55);
        check("t2_busy_low",   32'(busy),            32'h0);

        // 0xA3 with a low stop bit, line held low 40 clocks (break).
        d0 = done_count;
        send_frame(8'hA3, 1'b0);
        wait_clks(40);
        check("t3_done_cnt", 32'(done_count - d0), 32'd1);
        check("t3_out",      32'(out),             32'hA3);
        check("t3_err",      32'(err),             32'h1);
        check("t3_busy_brk", 32'(busy),            32'h0);
        rx = 1'b1;
        wait_clks(20);
        check("t3_no_second", 32'(done_count - d0), 32'd1);
        check("t3_err_held",  32'(err),             32'h1);

        // Back-to-back 0xA3 then 0x3C.
        d0 = done_count;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_clks(5);
        check("t4_done_cnt", 32'(done_count - d0), 32'd2);
        if (done_count - d0 == 2) begin
            check("t4_out0", 32'(cap_out[d0]),     32'hA3);
            check("t4_err0", 32'(cap_err[d0]),     32'h0);
            check("t4_out1", 32'(cap_out[d0 + 1]), 32'h3C);
        end
        check("t4_out", 32'(out), 32'h3C);
        check("t4_err", 32'(err), 32'h0);

        // Reset during data bit 4 of 0xFF.
        d0 = done_count;
        rx = 1'b0;
        wait_clks(SPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_clks(SPB / 2);
        check("t5_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(2);
        check("t5_out",  32'(out),  32'h00);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_err",  32'(err),  32'h0);
        rst = 1'b0;
        wait_clks(SPB * 6);
        check("t5_no_done", 32'(done_count - d0), 32'd0);
        send_frame(8'h81, 1'b1);
        check("t5_next_cnt", 32'(done_count - d0), 32'd1);
        check("t5_next_out", 32'(out),             32'h81);
        wait_clks(10);

        // Enable dropped for 3 clocks mid data bits.
        d0 = done_count;
        abort_byte = 8'h5A;
        rx = 1'b0;
        wait_clks(SPB);
        for (int i = 0; i < 3; i++) drive_bit(abort_byte[i]);
        wait_clks(SPB / 2);
        en = 1'b0;
        rx = 1'b1;
        wait_clks(3);
        check("t6_busy_off", 32'(busy), 32'h0);
        en = 1'b1;
        wait_clks(SPB * 8);
        check("t6_no_done",  32'(done_count - d0), 32'd0);
        check("t6_out_kept", 32'(out),             32'h81);
        send_frame(8'h0F, 1'b1);
        check("t6_next_cnt", 32'(done_count - d0), 32'd1);
        check("t6_next_out", 32'(out),             32'h0F);
        check("t6_next_err", 32'(err),             32'h0);
        wait_clks(10);

        // Global properties over the whole run.
        check("done_one_clk",     32'(done_long),  32'd0);
        check("out_only_on_done", 32'(out_glitch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
